// File: rtl/prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_fetch_unit
// Brief    : Sequential instruction fetch with prefetch FIFO, multiple
//            outstanding memory requests and branch/jump redirection.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_fetch_unit #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    WORD_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] target_addr_i,
    input  logic                  target_valid_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  instr_req_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i
);

    localparam int c_cnt_w  = $clog2(MAX_OUTSTANDING + 2);
    localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_fcnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_sum_w  = c_cnt_w + c_fcnt_w;

    localparam logic [c_cnt_w-1:0]    c_max_out = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_sum_w-1:0]    c_depth   = c_sum_w'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0]    c_last    = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_step    = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [ADDR_WIDTH-1:0] r_exp_pc;
    logic [c_cnt_w-1:0]    r_outstanding;
    logic [c_cnt_w-1:0]    r_discard;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_pc_mem   [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] r_word_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_fcnt_w-1:0]   r_count;

    logic                  w_gnt;
    logic                  w_held;
    logic                  w_rsp;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [c_cnt_w-1:0]    w_out_next;
    logic [c_fcnt_w-1:0]   w_count_next;
    logic [c_sum_w-1:0]    w_credit;
    logic                  w_issue_seq;
    logic                  w_issue_redir;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic                  w_unused_addr_bits;

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    // A response arriving with nothing outstanding is ignored so the counters cannot underflow.
    assign w_gnt        = r_req & instr_gnt_i;
    assign w_held       = r_req & ~instr_gnt_i;
    assign w_rsp        = instr_rvalid_i & (r_outstanding != '0);
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & instr_ready_i;
    assign w_push       = w_rsp & (r_discard == '0) & ~target_valid_i;
    assign w_out_next   = r_outstanding + c_cnt_w'(w_gnt) - c_cnt_w'(w_rsp);
    assign w_count_next = r_count + c_fcnt_w'(w_push) - c_fcnt_w'(w_pop);
    assign w_credit     = c_sum_w'(w_count_next) + c_sum_w'(w_out_next);
    assign w_target     = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};

    assign w_issue_seq   = ~w_held & req_i & ~target_valid_i &
                           (w_out_next < c_max_out) & (w_credit < c_depth);
    // A redirect empties the FIFO, so the target fetch only needs request credit.
    assign w_issue_redir = ~w_held & req_i & target_valid_i &
                           (w_out_next < c_max_out) & (c_sum_w'(w_out_next) < c_depth);
    assign w_issue       = w_issue_seq | w_issue_redir;
    assign w_issue_addr  = target_valid_i ? w_target : r_fetch_addr;

    assign w_unused_addr_bits = ^target_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_addr  <= BOOT_ADDR;
            r_exp_pc      <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_req         <= 1'b0;
            r_addr        <= BOOT_ADDR;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_outstanding <= w_out_next;

            if (w_issue) begin
                r_req        <= 1'b1;
                r_addr       <= w_issue_addr;
                r_fetch_addr <= w_issue_addr + c_step;
            end else begin
                if (!w_held) begin
                    r_req <= 1'b0;
                end
                if (target_valid_i) begin
                    r_fetch_addr <= w_target;
                end
            end

            if (target_valid_i) begin
                // Everything in flight, plus a request still waiting for its grant, is stale.
                r_exp_pc  <= w_target;
                r_discard <= w_out_next + c_cnt_w'(w_held);
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
            end else begin
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - c_cnt_w'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= f_next_ptr(r_wr_ptr);
                    r_exp_pc <= r_exp_pc + c_step;
                end
                if (w_pop) begin
                    r_rd_ptr <= f_next_ptr(r_rd_ptr);
                end
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_exp_pc;
            r_word_mem[r_wr_ptr] <= instr_rdata_i;
        end
    end

    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_word_mem[r_rd_ptr] : '0;
    assign pc_o          = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign instr_req_o   = r_req;
    assign instr_addr_o  = r_addr;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(instr_rvalid_i && (r_outstanding == '0)))
                else $error("prefetch_fetch_unit: rvalid with no outstanding request");
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/prefetch_fetch_unit.md
# prefetch_fetch_unit

Parametrised instruction fetch unit with a prefetch FIFO and multiple outstanding memory requests. Sits between the instruction memory port (req/gnt/rvalid handshake) and the decode stage of the core. Issues sequential word fetches, buffers returned words together with their PCs, and supports redirection by a branch/jump target. Redirection flushes the buffer and discards stale in-flight responses.

## Interface
- ADDR_WIDTH, 32, instruction address width
- WORD_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, prefetch buffer entries (≥2)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (≥1)
- BOOT_ADDR, 0, first fetch address after reset (word-aligned)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_i  in  1  decode enables fetching
- target_addr_i  in  ADDR_WIDTH  redirect address
- target_valid_i  in  1  redirect strobe, one cycle
- instr_o  out  WORD_WIDTH  instruction at FIFO head
- pc_o  out  ADDR_WIDTH  address of instr_o
- instr_valid_o  out  1  FIFO non-empty
- instr_ready_i  in  1  decode accepts head this cycle
- instr_req_o  out  1  memory request (registered)
- instr_addr_o  out  ADDR_WIDTH  request address (registered)
- instr_gnt_i  in  1  request accepted this cycle
- instr_rvalid_i  in  1  response valid; in order, ≥1 cycle after gnt
- instr_rdata_i  in  WORD_WIDTH  response data

## Operation
- Registers:
  - fetch_addr: next address to issue.
  - exp_pc: PC of next kept response.
  - outstanding: 0..MAX_OUTSTANDING.
  - discard: responses still to drop.
  - FIFO of {pc, word}.
  - req_q and addr_q, which drive instr_req_o and instr_addr_o.
- Request protocol:
  - Once instr_req_o=1, it and instr_addr_o hold unchanged until the cycle instr_gnt_i=1, including across a redirect.
  - A grant counts only when instr_req_o=1.
- outstanding_next = outstanding + (req&gnt) − (rvalid).
- Issue condition, evaluated when the request is not held:
  - req_i=1, target_valid_i=0
  - outstanding_next < MAX_OUTSTANDING
  - fifo_count_next + outstanding_next < FIFO_DEPTH
- On issue: req_q←1, addr_q←fetch_addr, fetch_addr←fetch_addr+4. Otherwise req_q←0.
- Response handling, on rvalid:
  - If discard>0: drop the word, discard−1.
  - Else: push {exp_pc, rdata}, exp_pc+4.
- Pop on instr_valid_o & instr_ready_i.
- Redirect (target_valid_i=1):
  - FIFO cleared; a same-cycle pop and a same-cycle rvalid word are both discarded.
  - fetch_addr←exp_pc←{target_addr_i[ADDR_WIDTH-1:2],2'b00}.
  - discard←outstanding_next + (instr_req_o & ~instr_gnt_i). Any still-held stale request is discarded when it is answered.
  - Takes priority over issue and push.
- Address arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC+4 wraps to 0x0.
- Counter widths: outstanding and discard are $clog2(MAX_OUTSTANDING+2) bits.
- rvalid with outstanding=0 is a protocol violation: assertion fires, the response is ignored and no counter underflows.
- Reset values:
  - instr_req_o=0, instr_addr_o=BOOT_ADDR.
  - instr_valid_o=0, instr_o=0, pc_o=0.
  - FIFO empty, outstanding=discard=0.
  - fetch_addr=exp_pc=BOOT_ADDR.
  - Reset mid-operation abandons in-flight requests; memory is reset alongside.

## Timing
- Issue decision in cycle T gives instr_req_o=1 in T+1.
- Fastest path, gnt in T+1 and rvalid in T+2: instr_valid_o=1 in T+3.
- Redirect in cycle R with no held request: instr_req_o=1 with the target address in R+1; instr_valid_o=0 in R+1.
- Push into an empty FIFO: visible on instr_valid_o next cycle; no fall-through.
- Throughput is one word per cycle with gnt always high, rvalid one cycle later and MAX_OUTSTANDING≥2.
- FIFO full and pop in the same cycle: push allowed; the credit check guarantees a push never overflows.

## Test plan
- Reset then stream: rst 2 cycles, req_i=1, gnt=1, rvalid one cycle after gnt, ready=1 → request addrs 0x0, 0x4, 0x8…; first instr_valid_o 3 cycles after first issue, pc_o=0x0; one instruction per cycle after.
- Backpressure: ready=0, FIFO_DEPTH=4 → exactly 4 grants then instr_req_o=0. ready=1 → pcs 0x0–0xC delivered in order, fetching resumes at 0x10.
- Redirect with 2 outstanding: target 0x103 → both stale responses dropped. Next instr_valid_o has pc_o=0x100 and the data returned for 0x100.
- Redirect with held ungranted request at 0x8 (gnt=0): instr_addr_o stays 0x8 until gnt. Its response is dropped; the next request is 0x100.
- Redirect coincident with pop and rvalid: no word from the old stream ever appears on instr_o after the redirect cycle.
- Wrap: BOOT_ADDR=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc_o matches each.
